mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single line-wide data memory between the instruction cache (read-only) and the
//  data cache (read/write). Sequences Read/Write toward memory, waits for Ready, returns the line
//  to the winner with a one-cycle ready pulse. Sits between both cache miss units and data memory.
// PARAMETERS
//  ADDR_W   28   line address width (WORD_SIZE-INDEX_SIZE)
//  LINE_W   128  cache line width (CACHE_LINE_SIZE)
//  TIMEOUT  64   max cycles in BUSY waiting for mem_ready before abort; >=8
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  i_req          in   1       icache line read request; held until i_ready
//  i_addr         in   ADDR_W  icache line address, stable while i_req
//  i_ready        out  1       1-cycle pulse: i_line valid
//  i_line         out  LINE_W  line returned to icache (registered)
//  d_rd, d_wr     in   1       dcache read / write-back request; held until d_ready
//  d_addr         in   ADDR_W  dcache line address, stable while request
//  d_wdata        in   LINE_W  write-back line, stable while d_wr
//  d_ready        out  1       1-cycle pulse: read line valid / write committed
//  d_line         out  LINE_W  line returned to dcache (registered)
//  mem_addr       out  ADDR_W  to memory Address
//  mem_wdata      out  LINE_W  to memory Line_in
//  mem_read       out  1       to memory Read
//  mem_write      out  1       to memory Write
//  mem_ready      in   1       from memory Ready
//  mem_rdata      in   LINE_W  from memory Line_out
//  timeout        out  1       1-cycle pulse, accompanies aborted ready pulse
//  err            out  1       sticky: timeout occurred or d_rd&d_wr seen; cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, last_grant=I (so D wins first tie), counter 0.
//  All outputs registered. mem_read and mem_write never both 1.
//  FSM IDLE -> BUSY -> RELEASE -> IDLE.
//  IDLE: pending I = i_req, D = d_rd|d_wr. One pending -> grant it. Both -> grant the one not
//   equal to last_grant (round robin). On grant: latch owner, mem_addr, mem_wdata (d_wdata),
//   set mem_read (i_req or d_rd) or mem_write (d_wr), update last_grant, counter=0, go BUSY.
//   d_rd&d_wr together: treat as write, set err.
//  BUSY: hold command and address. Each cycle counter+1. On edge sampling mem_ready=1:
//   read -> capture mem_rdata into owner's line reg; write is committed by memory on this same edge.
//   Then drop mem_read/mem_write, pulse owner's ready, go RELEASE.
//   counter==TIMEOUT-1 without mem_ready -> drop command, pulse owner's ready + timeout,
//   line reg unchanged, set err, go RELEASE.
//  RELEASE: one cycle, command low (memory clears its latency pipeline), ready pulse deasserts,
//   go IDLE. Requests are not sampled here.
//  Latency (nominal memory, 5 edges after Read/Write first sampled): request seen at edge E0 ->
//   command asserted after E0 -> mem_ready sampled at E6 -> ready pulse in cycle E6..E7 ->
//   IDLE at E7, next grant at E8 earliest (back-to-back spacing 8 cycles).
//  Requester must drop request on the edge after its ready pulse; a request still high in IDLE
//   is a new transaction.
//  mem_ready while IDLE/RELEASE: ignored. Request dropped mid-BUSY: transaction completes anyway.
//  rst mid-BUSY: immediate return to reset values; memory command drops asynchronously.
// TESTING
//  1. i_req, i_addr=0x10, mem model 5-edge latency, mem_rdata=A5..A5 -> mem_read 1 for 6 cycles,
//     i_ready 1 cycle at E6, i_line=A5..A5, d_ready stays 0.
//  2. d_wr, d_addr=0x3, d_wdata=0xDEAD_BEEF... -> mem_write held until mem_ready, model mem[3]
//     updated, d_ready pulse, mem_read never 1.
//  3. i_req and d_rd same cycle from reset -> D served first, then I at E8; second tie -> I first.
//  4. Memory never asserts mem_ready, TIMEOUT=64 -> command drops after 64 BUSY cycles, ready and
//     timeout pulse together, err=1 and stays 1 after further good transactions.
//  5. rst asserted 3 cycles into BUSY -> all outputs 0 same cycle; after release, new d_rd
//     completes normally with 6-cycle latency.
//  6. d_rd&d_wr asserted -> write performed, err=1, mem_read and mem_write never high together.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: icache and dcache miss ports plus the data-memory port.
// The slave modport is the arbiter's view; master is the caches/memory environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [LINE_W-1:0] i_line;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ready;
  logic [LINE_W-1:0] d_line;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
  logic              timeout;
  logic              err;

  modport slave (
    input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_ready, i_line, d_ready, d_line, mem_addr, mem_wdata, mem_read, mem_write,
           timeout, err
  );

  modport master (
    output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_ready, i_line, d_ready, d_line, mem_addr, mem_wdata, mem_read, mem_write,
           timeout, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide data memory between icache reads and dcache
// reads/write-backs; every transaction runs IDLE -> BUSY -> RELEASE with a bounded wait.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, i_line_q, i_line_d, d_line_q, d_line_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              i_rdy_q, i_rdy_d, d_rdy_q, d_rdy_d;
  logic              to_q, to_d, err_q, err_d;
  logic              d_pend, d_wins, done;

  assign d_pend = bus.d_rd | bus.d_wr;
  // On a tie the requester that did not win last time goes first.
  assign d_wins = d_pend & (~bus.i_req | (last_q == OWN_I));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    i_line_d = i_line_q;
    d_line_d = d_line_q;
    i_rdy_d  = 1'b0;
    d_rdy_d  = 1'b0;
    to_d     = 1'b0;
    err_d    = err_q;
    done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req || d_pend) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          wdata_d = bus.d_wdata;
          if (d_wins) begin
            owner_d = OWN_D;
            last_d  = OWN_D;
            addr_d  = bus.d_addr;
            wr_d    = bus.d_wr;
            rd_d    = ~bus.d_wr;  // simultaneous rd+wr is performed as a write
            err_d   = err_q | (bus.d_rd & bus.d_wr);
          end else begin
            owner_d = OWN_I;
            last_d  = OWN_I;
            addr_d  = bus.i_addr;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
          end
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_ready) begin
          done = 1'b1;
          if (rd_q && owner_q == OWN_I) i_line_d = bus.mem_rdata;
          if (rd_q && owner_q == OWN_D) d_line_d = bus.mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: owner still gets its ready pulse, line register keeps its old value.
          done  = 1'b1;
          to_d  = 1'b1;
          err_d = 1'b1;
        end
        if (done) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          i_rdy_d = (owner_q == OWN_I);
          d_rdy_d = (owner_q == OWN_D);
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_I;
      last_q   <= OWN_I;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      i_line_q <= '0;
      d_line_q <= '0;
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      to_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      i_line_q <= i_line_d;
      d_line_q <= d_line_d;
      i_rdy_q  <= i_rdy_d;
      d_rdy_q  <= d_rdy_d;
      to_q     <= to_d;
      err_q    <= err_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.i_ready   = i_rdy_q;
  assign bus.i_line    = i_line_q;
  assign bus.d_ready   = d_rdy_q;
  assign bus.d_line    = d_line_q;
  assign bus.timeout   = to_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grant order, pulse
// timing, returned lines and err, against a line memory with programmable latency.
module tb_mem_arbiter;
  localparam int TIMEOUT = 64;

  typedef struct {
    bit           is_d;
    bit           wr;
    bit           to;
    int           lat_edges;
    logic [27:0]  addr;
    logic [127:0] line;
  } exp_t;

  logic clk;
  logic rst;
  mem_arbiter_if bus ();

  mem_arbiter #(.ADDR_W(28), .LINE_W(128), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory and its latency control.
  logic [127:0] mem     [32];
  int           mem_lat;   // 0 = never answers
  int           mcnt;
  bit           spur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt = 0;
      bus.mem_ready <= 1'b0;
    end else if (bus.mem_read || bus.mem_write) begin
      if (bus.mem_ready) begin
        if (bus.mem_write) mem[bus.mem_addr[4:0]] = bus.mem_wdata;
        bus.mem_ready <= 1'b0;
        mcnt = 0;
      end else begin
        mcnt++;
        if (mem_lat != 0 && mcnt == mem_lat) begin
          bus.mem_ready <= 1'b1;
          bus.mem_rdata <= mem[bus.mem_addr[4:0]];
        end
      end
    end else begin
      mcnt = 0;
      bus.mem_ready <= spur;
      if (spur) bus.mem_rdata <= {4{32'hBAD0_F00D}};
    end
  end

  // Reference model state.
  logic [127:0] ref_mem [32];
  bit           model_last_d;
  bit           model_err;
  logic [127:0] model_iline;
  logic [127:0] model_dline;

  int n_checks;
  int n_bad;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_last_d = 1'b0;
    model_err    = 1'b0;
    model_iline  = '0;
    model_dline  = '0;
  endtask

  task automatic drive_idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_rd    = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"},  bus.mem_read,  1'b0);
    check({tag, "_mem_write"}, bus.mem_write, 1'b0);
    check({tag, "_mem_addr"},  bus.mem_addr,  '0);
    check({tag, "_i_ready"},   bus.i_ready,   1'b0);
    check({tag, "_d_ready"},   bus.d_ready,   1'b0);
    check({tag, "_i_line"},    bus.i_line,    '0);
    check({tag, "_d_line"},    bus.d_line,    '0);
    check({tag, "_timeout"},   bus.timeout,   1'b0);
    check({tag, "_err"},       bus.err,       1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One round: raise the given requests in IDLE, serve everything they generate.
  // Called and returns at a negedge with the arbiter in IDLE.
  task automatic round(input bit ir, input bit dr, input bit dw,
                       input logic [27:0] ia, input logic [27:0] da,
                       input logic [127:0] wd, input int lat);
    exp_t q[$];
    bit   ip;
    bit   dp;
    int   e;
    int   g;
    int   n;
    int   p;
    bit   active;

    ip = ir;
    dp = dr | dw;
    while (ip || dp) begin
      exp_t t;
      t.is_d      = dp && (!ip || !model_last_d);
      t.to        = (lat == 0);
      t.lat_edges = t.to ? TIMEOUT : lat + 1;
      if (t.is_d) begin
        t.wr   = dw;
        t.addr = da;
        dp     = 1'b0;
        if (dr && dw) model_err = 1'b1;
        if (!t.to && dw)      ref_mem[da[4:0]] = wd;
        else if (!t.to)       model_dline = ref_mem[da[4:0]];
        t.line = model_dline;
      end else begin
        t.wr   = 1'b0;
        t.addr = ia;
        ip     = 1'b0;
        if (!t.to) model_iline = ref_mem[ia[4:0]];
        t.line = model_iline;
      end
      if (t.to) model_err = 1'b1;
      model_last_d = t.is_d;
      q.push_back(t);
    end

    mem_lat     = lat;
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_rd    = dr;
    bus.d_wr    = dw;
    bus.d_addr  = da;
    bus.d_wdata = wd;

    e = 0;
    g = 0;
    n = 0;
    while (n < q.size()) begin
      @(negedge clk);
      p      = g + q[n].lat_edges;
      active = (e >= g) && (e < p);
      check("i_ready",   bus.i_ready,   (e == p) && !q[n].is_d);
      check("d_ready",   bus.d_ready,   (e == p) &&  q[n].is_d);
      check("mem_read",  bus.mem_read,  active && !q[n].wr);
      check("mem_write", bus.mem_write, active &&  q[n].wr);
      if (e == g) begin
        check("mem_addr", bus.mem_addr, q[n].addr);
        if (q[n].wr) check("mem_wdata", bus.mem_wdata, wd);
      end
      if (e == p) begin
        check("timeout", bus.timeout, q[n].to);
        if (q[n].is_d) begin
          check("d_line", bus.d_line, q[n].line);
          bus.d_rd = 1'b0;
          bus.d_wr = 1'b0;
        end else begin
          check("i_line", bus.i_line, q[n].line);
          bus.i_req = 1'b0;
        end
        g = p + 2;
        n++;
      end
      e++;
      if (e > 400) begin
        check("round_bound", 128'(e), 128'(0));
        break;
      end
    end
    @(negedge clk);
    check("rel_i_ready", bus.i_ready, 1'b0);
    check("rel_d_ready", bus.d_ready, 1'b0);
    check("err", bus.err, model_err);
    if (dr || dw) check("mem_commit", mem[da[4:0]], ref_mem[da[4:0]]);
  endtask

  initial begin
    logic [127:0] v;
    n_checks = 0;
    n_bad    = 0;
    spur     = 1'b0;
    mem_lat  = 5;
    rst      = 1'b1;
    bus.mem_rdata = '0;
    drive_idle();
    for (int i = 0; i < 32; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      mem[i]     = v;
      ref_mem[i] = v;
    end
    mem[16]     = {16{8'hA5}};
    ref_mem[16] = {16{8'hA5}};

    do_reset();

    // Ties from reset: D first, then I eight edges later; D alone; tie again -> I first.
    round(1, 1, 0, 28'h1, 28'h2, '0, 5);
    round(0, 1, 0, 28'h0, 28'h4, '0, 5);
    round(1, 1, 0, 28'h7, 28'h5, '0, 5);

    // Single icache read, dcache write-back, read-back of the written line.
    round(1, 0, 0, 28'h10, 28'h0, '0, 5);
    round(0, 0, 1, 28'h0, 28'h3, {4{32'hDEAD_BEEF}}, 5);
    round(0, 1, 0, 28'h0, 28'h3, '0, 5);

    // mem_ready while idle must be ignored.
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_i_ready", bus.i_ready, 1'b0);
      check("spur_d_ready", bus.d_ready, 1'b0);
    end
    check("spur_i_line", bus.i_line, model_iline);
    check("spur_d_line", bus.d_line, model_dline);
    spur = 1'b0;
    @(negedge clk);

    // Simultaneous d_rd and d_wr: a write, and err set.
    round(0, 1, 1, 28'h0, 28'h6, {4{32'h1234_5678}}, 4);

    // Reset three cycles into BUSY, then a normal read.
    mem_lat    = 5;
    bus.d_rd   = 1'b1;
    bus.d_addr = 28'h2;
    repeat (4) @(negedge clk);
    check("pre_rst_mem_read", bus.mem_read, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_busy_rst");
    drive_idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    round(0, 1, 0, 28'h0, 28'h2, '0, 5);

    // Memory never answers: abort after TIMEOUT cycles; err stays set afterwards.
    round(1, 0, 0, 28'h5, 28'h0, '0, 0);
    round(0, 1, 0, 28'h0, 28'h5, '0, 3);
    round(1, 0, 0, 28'h10, 28'h0, '0, 2);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      bit ir, dr, dw;
      int kind;
      int lat;
      ir   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 7);
      dr   = (kind == 3 || kind == 4 || kind == 7);
      dw   = (kind == 5 || kind == 6 || kind == 7);
      if (!ir && !dr && !dw) ir = 1'b1;
      lat  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 8);
      round(ir, dr, dw, 28'($urandom_range(0, 7)), 28'($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom, $urandom}, lat);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
